// File: rtl/bcd_conv_seq_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD sequencer.
// BCD_FOUR_DIGIT_EN adds the thousands digit (digito3).
interface bcd_conv_seq_if;
   logic        start;
   logic [31:0] _input;
   logic        busy;
   logic        done;
   logic        sinal;
   logic        overflow;
   logic [3:0]  digito0;
   logic [3:0]  digito1;
   logic [3:0]  digito2;
`ifdef BCD_FOUR_DIGIT_EN
   logic [3:0]  digito3;

   modport master (
      output start, _input,
      input  busy, done, sinal, overflow, digito0, digito1, digito2, digito3
   );
   modport slave (
      input  start, _input,
      output busy, done, sinal, overflow, digito0, digito1, digito2, digito3
   );
`else
   modport master (
      output start, _input,
      input  busy, done, sinal, overflow, digito0, digito1, digito2
   );
   modport slave (
      input  start, _input,
      output busy, done, sinal, overflow, digito0, digito1, digito2
   );
`endif
endinterface

// File: rtl/bcd_conv_seq.sv
// Sequential signed binary-to-BCD converter (double-dabble, one bit per clock).
// BCD_FOUR_DIGIT_EN selects four digits (0..9999) instead of three (0..999).
module bcd_conv_seq (
   input  logic             clk,
   input  logic             rst_n,
   bcd_conv_seq_if.slave    bus
);

`ifdef BCD_FOUR_DIGIT_EN
   localparam int NDIG = 4;
   localparam int W    = 14;
   localparam int MAXV = 9999;
`else
   localparam int NDIG = 3;
   localparam int W    = 10;
   localparam int MAXV = 999;
`endif
   localparam int SW = 4 * NDIG;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [W-1:0]    shreg_reg, shreg_next;
   logic [SW-1:0]   scratch_reg, scratch_next;
   logic [3:0]      cnt_reg, cnt_next;
   logic            sinal_r_reg, sinal_r_next;
   logic            ovf_r_reg, ovf_r_next;

   logic            done_reg, done_next;
   logic            sinal_reg, sinal_next;
   logic            overflow_reg, overflow_next;
   logic [SW-1:0]   digits_reg, digits_next;

   logic [31:0]     mag;
   logic [SW-1:0]   scratch_adj;
   logic [SW-1:0]   scratch_shifted;
   logic            scratch_carry;

   // -2147483648 negates to itself; it stays 0x80000000 and fails the range test.
   assign mag = bus._input[31] ? (~bus._input + 32'd1) : bus._input;

   genvar gi;
   generate
      for (gi = 0; gi < NDIG; gi++) begin : g_adj
         assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                       ? scratch_reg[4*gi +: 4] + 4'd3
                                       : scratch_reg[4*gi +: 4];
      end
   endgenerate

   assign {scratch_carry, scratch_shifted} = {scratch_adj, shreg_reg[W-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         shreg_reg    <= '0;
         scratch_reg  <= '0;
         cnt_reg      <= '0;
         sinal_r_reg  <= 1'b0;
         ovf_r_reg    <= 1'b0;
         done_reg     <= 1'b0;
         sinal_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         digits_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         shreg_reg    <= shreg_next;
         scratch_reg  <= scratch_next;
         cnt_reg      <= cnt_next;
         sinal_r_reg  <= sinal_r_next;
         ovf_r_reg    <= ovf_r_next;
         done_reg     <= done_next;
         sinal_reg    <= sinal_next;
         overflow_reg <= overflow_next;
         digits_reg   <= digits_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      shreg_next    = shreg_reg;
      scratch_next  = scratch_reg;
      cnt_next      = cnt_reg;
      sinal_r_next  = sinal_r_reg;
      ovf_r_next    = ovf_r_reg;
      done_next     = 1'b0;
      sinal_next    = sinal_reg;
      overflow_next = overflow_reg;
      digits_next   = digits_reg;

      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next   = SHIFT;
               shreg_next   = mag[W-1:0];
               scratch_next = '0;
               cnt_next     = 4'(W - 1);
               sinal_r_next = bus._input[31];
               ovf_r_next   = (mag > 32'(MAXV));
            end
         end
         SHIFT: begin
            scratch_next = scratch_shifted;
            shreg_next   = {shreg_reg[W-2:0], 1'b0};
            cnt_next     = cnt_reg - 4'd1;
            if (cnt_reg == 4'd0) begin
               // Results are taken from the final shift so they appear on the edge entering DONE.
               // A bit carried out of the top digit only occurs for out-of-range values.
               state_next    = DONE;
               done_next     = 1'b1;
               sinal_next    = sinal_r_reg;
               overflow_next = ovf_r_reg;
               digits_next   = (ovf_r_reg || scratch_carry) ? {NDIG{4'd9}} : scratch_shifted;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.busy     = (state_reg != IDLE);
   assign bus.done     = done_reg;
   assign bus.sinal    = sinal_reg;
   assign bus.overflow = overflow_reg;
   assign bus.digito0  = digits_reg[3:0];
   assign bus.digito1  = digits_reg[7:4];
   assign bus.digito2  = digits_reg[11:8];
`ifdef BCD_FOUR_DIGIT_EN
   assign bus.digito3  = digits_reg[15:12];
`endif

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Self-checking bench for bcd_conv_seq: vector table plus reset and handshake sequences.
// Builds for either digit count (BCD_FOUR_DIGIT_EN).
module tb_bcd_conv_seq;

`ifdef BCD_FOUR_DIGIT_EN
   localparam int W = 14;
`else
   localparam int W = 10;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   bcd_conv_seq_if bus ();

   bcd_conv_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] value;
      logic        exp_sinal;
      logic        exp_ovf;
      logic [15:0] exp_digits;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [15:0] get_digits();
`ifdef BCD_FOUR_DIGIT_EN
      return {bus.digito3, bus.digito2, bus.digito1, bus.digito0};
`else
      return {4'd0, bus.digito2, bus.digito1, bus.digito0};
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Runs one conversion and checks handshake timing and results.
   task automatic run_vec(input vec_t v);
      int lat;
      bit seen;
      @(negedge clk);
      bus._input = v.value;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      chk("busy_at_accept", 32'(bus.busy), 32'd1);
      chk("done_at_accept", 32'(bus.done), 32'd0);
      bus.start = 1'b0;
      lat  = 1;
      seen = 1'b0;
      for (int i = 0; i < 4 * W; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("latency", 32'(lat), 32'(W + 1));
      chk("busy_in_done", 32'(bus.busy), 32'd1);
      chk("sinal", 32'(bus.sinal), 32'(v.exp_sinal));
      chk("overflow", 32'(bus.overflow), 32'(v.exp_ovf));
      chk("digits", 32'(get_digits()), 32'(v.exp_digits));
      $display("vec in=0x%08h lat=%0d sinal=%0b ovf=%0b digits=%04h", v.value, lat,
               bus.sinal, bus.overflow, get_digits());
      @(posedge clk);
      #1;
      chk("done_pulse_end", 32'(bus.done), 32'd0);
      chk("busy_end", 32'(bus.busy), 32'd0);
      chk("digits_hold", 32'(get_digits()), 32'(v.exp_digits));
   endtask

   initial begin
      int t_done[2];
      int n_done;
      int cyc;
      bit done_after_rst;

      checks = 0;
      errors = 0;

`ifdef BCD_FOUR_DIGIT_EN
      vecs[0] = '{32'd9999,       1'b0, 1'b0, 16'h9999};
      vecs[1] = '{32'd10000,      1'b0, 1'b1, 16'h9999};
      vecs[2] = '{32'd1234,       1'b0, 1'b0, 16'h1234};
      vecs[3] = '{32'd255,        1'b0, 1'b0, 16'h0255};
      vecs[4] = '{32'hFFFFFFD6,   1'b1, 1'b0, 16'h0042};
      vecs[5] = '{32'd0,          1'b0, 1'b0, 16'h0000};
      vecs[6] = '{32'd1000,       1'b0, 1'b0, 16'h1000};
      vecs[7] = '{32'hFFFFD8F0,   1'b1, 1'b1, 16'h9999};
      vecs[8] = '{32'h80000000,   1'b1, 1'b1, 16'h9999};
`else
      vecs[0] = '{32'd255,        1'b0, 1'b0, 16'h0255};
      vecs[1] = '{32'hFFFFFFD6,   1'b1, 1'b0, 16'h0042};
      vecs[2] = '{32'd0,          1'b0, 1'b0, 16'h0000};
      vecs[3] = '{32'd1000,       1'b0, 1'b1, 16'h0999};
      vecs[4] = '{32'd999,        1'b0, 1'b0, 16'h0999};
      vecs[5] = '{32'hFFFFFC19,   1'b1, 1'b0, 16'h0999};
      vecs[6] = '{32'd1023,       1'b0, 1'b1, 16'h0999};
      vecs[7] = '{32'd506,        1'b0, 1'b0, 16'h0506};
      vecs[8] = '{32'h80000000,   1'b1, 1'b1, 16'h0999};
`endif

      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus._input = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_sinal", 32'(bus.sinal), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_digits", 32'(get_digits()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i]);
      end

      // Reset in the middle of SHIFT aborts the conversion immediately.
      @(negedge clk);
      bus._input = 32'd123;
      bus.start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_sinal", 32'(bus.sinal), 32'd0);
      chk("midrst_overflow", 32'(bus.overflow), 32'd0);
      chk("midrst_digits", 32'(get_digits()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_after_rst = 1'b0;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) done_after_rst = 1'b1;
      end
      chk("midrst_no_done", 32'(done_after_rst), 32'd0);
      chk("midrst_idle", 32'(bus.busy), 32'd0);
      $display("reset mid-conversion: busy=%0b done_seen=%0b", bus.busy, done_after_rst);

      // start held high: 7 converts, input changes to 8 while busy, 8 is accepted afterwards.
      @(negedge clk);
      bus._input = 32'd7;
      bus.start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus._input = 32'd8;
      n_done = 0;
      cyc    = 0;
      for (int i = 0; i < 6 * W; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.done) begin
            t_done[n_done] = cyc;
            chk(n_done == 0 ? "hs_first_digits" : "hs_second_digits", 32'(get_digits()),
                n_done == 0 ? 32'h0007 : 32'h0008);
            $display("handshake done #%0d at cycle %0d digits=%04h", n_done, cyc, get_digits());
            n_done++;
            if (n_done == 2) break;
         end
      end
      @(negedge clk);
      bus.start = 1'b0;
      chk("hs_done_count", 32'(n_done), 32'd2);
      if (n_done == 2) chk("hs_spacing", 32'(t_done[1] - t_done[0]), 32'(W + 2));
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("hs_idle_after", 32'(bus.busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
